// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port, synchronous-read text VRAM between the video character fetcher and the CPU bus.
// Latency: video slot -> MEM_ADDR +1, CHAR_* +3; CPU REQ -> ACK 2 (write) / 3 (read), one more if it meets a video slot.
// Backpressure: video slots always own MEM; the CPU waits in IDLE on its level REQ and completes with a one-cycle ACK.
//
// Ports:
//   i_clk_pixel, i_reset         pixel clock, asynchronous active-high reset
//   i_screen_x/y                 beam position from the timing generator
//   i_cpu_req/we/addr/wdata      CPU request (level, held until o_cpu_ack)
//   o_cpu_ack, o_cpu_rdata       completion pulse, read data (held after ACK)
//   o_mem_addr/we/wdata          registered VRAM port, i_mem_rdata one cycle after o_mem_addr
//   o_char_code/row/valid        fetched character, glyph row, one-cycle update strobe
module vram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int COLS   = 100,
    parameter int CELL_W = 8,
    parameter int CELL_H = 16,
    parameter int HA_END = 799,
    parameter int VA_END = 599,
    parameter int LINE   = 1055,
    parameter int SCREEN = 627
) (
    input  logic              i_clk_pixel,
    input  logic              i_reset,
    input  logic [10:0]       i_screen_x,
    input  logic [10:0]       i_screen_y,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_char_code,
    output logic [3:0]        o_char_row,
    output logic              o_char_valid
);

    localparam int CW_SH       = $clog2(CELL_W);
    localparam int CH_SH       = $clog2(CELL_H);
    // Column c is fetched one cell ahead of where it is drawn, so the last
    // in-line slot belongs to column COLS-1 and sits at X = CELL_W*(COLS-2).
    localparam int LAST_SLOT_X = CELL_W * (COLS - 2);
    // Column 0 of the next line is fetched one cell before the line wraps.
    localparam int EOL_X       = LINE - CELL_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RDWAIT,
        S_ACK
    } state_t;

    // ------------------------------------------------------------------
    // Video slot decode on the current beam position
    // ------------------------------------------------------------------
    logic [10:0]       w_next_y;
    logic [10:0]       w_fetch_y;
    logic [10:0]       w_fetch_col;
    logic              w_slot_col;
    logic              w_slot_eol;
    logic              w_slot;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [3:0]        w_fetch_row;

    always_comb begin
        w_next_y     = (i_screen_y == 11'(SCREEN)) ? 11'd0 : i_screen_y + 11'd1;
        // HA_END keeps fetches inside the active region; with the default
        // geometry the column limit is the tighter of the two bounds.
        w_slot_col   = ((i_screen_x & 11'(CELL_W - 1)) == 11'd0)
                     && (i_screen_x <= 11'(LAST_SLOT_X))
                     && (i_screen_x <= 11'(HA_END))
                     && (i_screen_y <= 11'(VA_END));
        w_slot_eol   = (i_screen_x == 11'(EOL_X)) && (w_next_y <= 11'(VA_END));
        w_slot       = w_slot_col || w_slot_eol;
        w_fetch_y    = w_slot_eol ? w_next_y : i_screen_y;
        w_fetch_col  = w_slot_eol ? 11'd0 : (i_screen_x >> CW_SH) + 11'd1;
        w_fetch_addr = ADDR_W'(32'(w_fetch_y >> CH_SH) * COLS + 32'(w_fetch_col));
        w_fetch_row  = 4'(w_fetch_y & 11'(CELL_H - 1));
    end

    // ------------------------------------------------------------------
    // VRAM port ownership and CPU handshake FSM
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_cpu_we;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;

    always_ff @(posedge i_clk_pixel or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cpu_we    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we  <= 1'b0;
            r_cpu_ack <= 1'b0;

            // A video slot takes MEM regardless of CPU state; the CPU holds
            // MEM for its single ISSUE cycle only, so nothing is displaced.
            if (w_slot) begin
                r_mem_addr <= w_fetch_addr;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req && !w_slot) begin
                        r_mem_addr  <= i_cpu_addr;
                        r_mem_we    <= i_cpu_we;
                        r_mem_wdata <= i_cpu_wdata;
                        r_cpu_we    <= i_cpu_we;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_cpu_we) begin
                        r_cpu_ack <= 1'b1;
                        r_state   <= S_ACK;
                    end else begin
                        r_state   <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    // Read data for the ISSUE-cycle address is on the bus now,
                    // even if a video slot has since retargeted MEM_ADDR.
                    r_cpu_rdata <= i_mem_rdata;
                    r_cpu_ack   <= 1'b1;
                    r_state     <= S_ACK;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Video fetch pipeline: slot -> address -> BRAM data -> character
    // ------------------------------------------------------------------
    logic              r_vid_p1;
    logic              r_vid_p2;
    logic [3:0]        r_row_p1;
    logic [3:0]        r_row_p2;
    logic [DATA_W-1:0] r_char_code;
    logic [3:0]        r_char_row;
    logic              r_char_valid;

    always_ff @(posedge i_clk_pixel or posedge i_reset) begin
        if (i_reset) begin
            r_vid_p1     <= 1'b0;
            r_vid_p2     <= 1'b0;
            r_row_p1     <= '0;
            r_row_p2     <= '0;
            r_char_code  <= '0;
            r_char_row   <= '0;
            r_char_valid <= 1'b0;
        end else begin
            r_vid_p1     <= w_slot;
            r_row_p1     <= w_fetch_row;
            r_vid_p2     <= r_vid_p1;
            r_row_p2     <= r_row_p1;
            r_char_valid <= r_vid_p2;
            if (r_vid_p2) begin
                r_char_code <= i_mem_rdata;
                r_char_row  <= r_row_p2;
            end
        end
    end

    assign o_cpu_ack    = r_cpu_ack;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_we     = r_mem_we;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_char_code  = r_char_code;
    assign o_char_row   = r_char_row;
    assign o_char_valid = r_char_valid;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter against a synchronous-read VRAM model.
// Latency: inputs change on the falling edge, outputs are observed on the falling edge.
// Backpressure: the bench holds CPU_REQ until ACK, as the CPU bridge does.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] sx = '0;
    logic [10:0] sy = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  char_code;
    logic [3:0]  char_row;
    logic        char_valid;

    logic        bd_we = 1'b0;
    logic [12:0] bd_a = '0;
    logic [7:0]  bd_d = '0;
    logic [7:0]  ram [8192];
    logic [7:0]  ref_mem [8192];

    int n_checks = 0;
    int n_fail   = 0;

    // frame-walk state
    bit   pv_v [4];
    int   pv_a [4];
    int   pv_r [4];
    int   pv_f [4];
    int   line_cnt [596:599];
    int   n_pulse, n_ack, lat;
    int   we_err, vaddr_err, vld_err, code_err, wr_err, rd_err, lat_err;
    logic        cur_we;
    logic [12:0] cur_addr;
    logic [7:0]  cur_data;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .i_clk_pixel (clk),
        .i_reset     (rst),
        .i_screen_x  (sx),
        .i_screen_y  (sy),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_ack   (cpu_ack),
        .o_cpu_rdata (cpu_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_char_code (char_code),
        .o_char_row  (char_row),
        .o_char_valid(char_valid)
    );

    // Single-port synchronous-read VRAM with a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) ram[bd_a] <= bd_d;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance the beam one pixel; outputs observed afterwards belong to the new X.
    task automatic step();
        @(negedge clk);
        if (sx == 11'd1055) begin
            sx = '0;
            sy = (sy == 11'd627) ? 11'd0 : sy + 11'd1;
        end else begin
            sx = sx + 11'd1;
        end
    endtask

    task automatic goto_xy(input int x, input int y);
        sx = 11'(x);
        sy = 11'(y);
    endtask

    task automatic poke(input int a, input int d);
        bd_we = 1'b1;
        bd_a  = 13'(a);
        bd_d  = 8'(d);
        ref_mem[a] = 8'(d);
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic cpu_set(input logic req, input logic we, input int a, input int d);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = 13'(a);
        cpu_wdata = 8'(d);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"},    32'(cpu_ack),    0);
        chk({tag, "_rdata"},  32'(cpu_rdata),  0);
        chk({tag, "_maddr"},  32'(mem_addr),   0);
        chk({tag, "_mwe"},    32'(mem_we),     0);
        chk({tag, "_mwdata"}, 32'(mem_wdata),  0);
        chk({tag, "_code"},   32'(char_code),  0);
        chk({tag, "_row"},    32'(char_row),   0);
        chk({tag, "_cvld"},   32'(char_valid), 0);
    endtask

    // Expected fetch for beam position (x,y): slot flag, address, glyph row, fetch line.
    function automatic void pred(input int x, input int y, output bit v, output int a,
                                 output int r, output int fy);
        v  = 0;
        a  = 0;
        fy = y;
        if ((x % 8) == 0 && x <= 8 * 98 && y <= 599) begin
            v = 1;
            a = (y / 16) * 100 + x / 8 + 1;
        end else if (x == 1048) begin
            fy = (y == 627) ? 0 : y + 1;
            if (fy <= 599) begin
                v = 1;
                a = (fy / 16) * 100;
            end
        end
        r = fy % 16;
    endfunction

    task automatic new_req();
        cur_we   = 1'($urandom_range(0, 1));
        cur_addr = 13'(4096 + $urandom_range(0, 15));
        cur_data = 8'($urandom_range(0, 255));
        cpu_set(1'b1, cur_we, int'(cur_addr), int'(cur_data));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        poke(205, 8'h41);
        poke(100, 8'h7E);
        poke(201, 8'h99);
        poke(0,   8'h33);
        poke(6,   8'h66);
        for (int c = 0; c < 100; c++) poke(3700 + c, (c * 7 + 1) & 255);
        for (int a = 4096; a < 4112; a++) poke(a, (a & 255) ^ 8'hA5);

        // ---------------- reset state ----------------
        check_all_zero("reset");
        rst = 1'b0;

        // ---------------- mid-line fetch ----------------
        goto_xy(32, 32);
        step();                                     // X=33
        chk("t1_maddr", 32'(mem_addr), 205);
        chk("t1_mwe",   32'(mem_we),   0);
        chk("t1_cvld_33", 32'(char_valid), 0);
        step();                                     // X=34
        chk("t1_cvld_34", 32'(char_valid), 0);
        step();                                     // X=35
        chk("t1_code",  32'(char_code),  8'h41);
        chk("t1_row",   32'(char_row),   0);
        chk("t1_cvld_35", 32'(char_valid), 1);
        step();                                     // X=36
        chk("t1_cvld_36", 32'(char_valid), 0);

        goto_xy(0, 37);                             // row 2, col 1, glyph row 5
        step();
        chk("t1b_maddr", 32'(mem_addr), 201);
        step();
        step();
        chk("t1b_code", 32'(char_code), 8'h99);
        chk("t1b_row",  32'(char_row),  5);
        chk("t1b_cvld", 32'(char_valid), 1);

        goto_xy(784, 0);                            // last column slot
        step();
        chk("t1c_last_col", 32'(mem_addr), 99);
        goto_xy(792, 0);                            // past the last slot
        step();
        chk("t1c_no_slot_hold", 32'(mem_addr), 99);

        // ---------------- end-of-line fetch ----------------
        goto_xy(1048, 15);
        step();                                     // X=1049
        chk("t2_maddr", 32'(mem_addr), 100);
        step();
        step();                                     // X=1051
        chk("t2_code", 32'(char_code), 8'h7E);
        chk("t2_row",  32'(char_row),  0);
        chk("t2_cvld", 32'(char_valid), 1);

        goto_xy(1048, 599);                         // next line is blanking
        step();
        chk("t2b_maddr_hold", 32'(mem_addr), 100);
        step();
        step();
        chk("t2b_no_cvld", 32'(char_valid), 0);

        goto_xy(1048, 627);                         // wraps to line 0
        step();
        chk("t2c_maddr", 32'(mem_addr), 0);
        step();
        step();
        chk("t2c_code", 32'(char_code), 8'h33);
        chk("t2c_cvld", 32'(char_valid), 1);

        // ---------------- CPU write then readback in blanking ----------------
        goto_xy(100, 610);
        cpu_set(1'b1, 1'b1, 12'h123, 8'h5A);
        step();                                     // ISSUE
        chk("t3_wr_mwe",    32'(mem_we),    1);
        chk("t3_wr_maddr",  32'(mem_addr),  12'h123);
        chk("t3_wr_mwdata", 32'(mem_wdata), 8'h5A);
        chk("t3_wr_ack0",   32'(cpu_ack),   0);
        step();                                     // ACK
        chk("t3_wr_ack",    32'(cpu_ack),   1);
        chk("t3_wr_mwe0",   32'(mem_we),    0);
        cpu_set(1'b0, 1'b0, 0, 0);
        step();
        chk("t3_wr_ack_pulse", 32'(cpu_ack), 0);
        cpu_set(1'b1, 1'b0, 12'h123, 0);
        step();                                     // ISSUE
        chk("t3_rd_maddr", 32'(mem_addr), 12'h123);
        chk("t3_rd_mwe",   32'(mem_we),   0);
        step();                                     // RDWAIT
        chk("t3_rd_ack0",  32'(cpu_ack),  0);
        step();                                     // ACK
        chk("t3_rd_ack",   32'(cpu_ack),   1);
        chk("t3_rd_data",  32'(cpu_rdata), 8'h5A);
        cpu_set(1'b0, 1'b0, 0, 0);
        step();
        chk("t3_rd_ack_pulse", 32'(cpu_ack),   0);
        chk("t3_rd_data_held", 32'(cpu_rdata), 8'h5A);

        // ---------------- CPU read colliding with a video slot ----------------
        goto_xy(40, 0);
        cpu_set(1'b1, 1'b0, 12'h123, 0);
        step();                                     // X=41
        chk("t4_video_first", 32'(mem_addr), 6);
        step();                                     // X=42
        chk("t4_cpu_second", 32'(mem_addr), 12'h123);
        step();                                     // X=43
        chk("t4_ack0",  32'(cpu_ack),    0);
        chk("t4_code",  32'(char_code),  8'h66);
        chk("t4_cvld",  32'(char_valid), 1);
        step();                                     // X=44
        chk("t4_ack",   32'(cpu_ack),   1);
        chk("t4_rdata", 32'(cpu_rdata), 8'h5A);
        cpu_set(1'b0, 1'b0, 0, 0);
        step();
        chk("t4_ack_pulse", 32'(cpu_ack), 0);

        // ---------------- reset during RDWAIT ----------------
        goto_xy(200, 620);
        cpu_set(1'b1, 1'b0, 12'h123, 0);
        step();                                     // ISSUE
        chk("t6_issue_maddr", 32'(mem_addr), 12'h123);
        step();                                     // RDWAIT
        rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        cpu_set(1'b0, 1'b0, 0, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("t6_no_ack", 32'(cpu_ack), 0);
        step();
        chk("t6_no_ack_late", 32'(cpu_ack), 0);
        cpu_set(1'b1, 1'b1, 12'h124, 8'hC3);        // must be taken straight from IDLE
        step();
        chk("t6_idle_mwe",   32'(mem_we),   1);
        chk("t6_idle_maddr", 32'(mem_addr), 12'h124);
        step();
        chk("t6_idle_ack",   32'(cpu_ack),  1);
        cpu_set(1'b0, 1'b0, 0, 0);
        step();

        // ---------------- CPU saturating across the bottom of the frame ----------------
        for (int k = 0; k < 4; k++) begin
            pv_v[k] = 0; pv_a[k] = 0; pv_r[k] = 0; pv_f[k] = 0;
        end
        for (int l = 596; l <= 599; l++) line_cnt[l] = 0;
        n_pulse = 0; n_ack = 0;
        we_err = 0; vaddr_err = 0; vld_err = 0; code_err = 0;
        wr_err = 0; rd_err = 0; lat_err = 0;
        goto_xy(1040, 595);
        new_req();
        lat = 0;
        while (sy != 11'd606) begin
            for (int k = 3; k > 0; k--) begin
                pv_v[k] = pv_v[k-1]; pv_a[k] = pv_a[k-1];
                pv_r[k] = pv_r[k-1]; pv_f[k] = pv_f[k-1];
            end
            pred(int'(sx), int'(sy), pv_v[0], pv_a[0], pv_r[0], pv_f[0]);

            if (mem_we && pv_v[1]) we_err++;
            if (pv_v[1] && mem_addr != 13'(pv_a[1])) vaddr_err++;
            if (mem_we && (mem_addr != cur_addr || mem_wdata != cur_data || !cur_we)) wr_err++;
            if (char_valid != pv_v[3]) begin
                vld_err++;
            end else if (char_valid) begin
                if (char_code != ref_mem[pv_a[3]] || char_row != 4'(pv_r[3])) code_err++;
                if (pv_f[3] >= 596 && pv_f[3] <= 599) line_cnt[pv_f[3]]++;
                else vld_err++;
                n_pulse++;
            end

            if (cpu_ack) begin
                if (lat > 4) lat_err++;
                if (cur_we) ref_mem[cur_addr] = cur_data;
                else if (cpu_rdata != ref_mem[cur_addr]) rd_err++;
                n_ack++;
                new_req();
                lat = -1;   // visible to the FSM from the cycle after ACK
            end
            lat++;
            step();
        end
        cpu_set(1'b0, 1'b0, 0, 0);
        chk("t5_mem_we_in_video", 32'(we_err), 0);
        chk("t5_video_addr",      32'(vaddr_err), 0);
        chk("t5_char_valid_timing", 32'(vld_err), 0);
        chk("t5_char_data",       32'(code_err), 0);
        chk("t5_cpu_write_port",  32'(wr_err), 0);
        chk("t5_cpu_read_data",   32'(rd_err), 0);
        chk("t5_ack_latency",     32'(lat_err), 0);
        chk("t5_ack_count_ok",    32'(n_ack >= 2000), 1);
        chk("t5_pulses_l596",     32'(line_cnt[596]), 100);
        chk("t5_pulses_l597",     32'(line_cnt[597]), 100);
        chk("t5_pulses_l598",     32'(line_cnt[598]), 100);
        chk("t5_pulses_l599",     32'(line_cnt[599]), 100);
        chk("t5_pulses_total",    32'(n_pulse), 400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
